// File: rtl/viterbi_chan_err_inj_pkg.sv
// Shared types and constants for the Viterbi channel error injector.
//   err_mode_e : word-selection policy (OFF / PERIODIC / BURST / RANDOM)
//   LFSR_SEED  : value loaded into the selection LFSR on reset and clear
//   LFSR_TAPS  : Galois tap mask for x^16 + x^14 + x^13 + x^11
//   popcount   : number of set bits in a vector of up to 64 bits
package viterbi_chan_pkg;

    typedef enum logic [1:0] {
        ERR_OFF      = 2'd0,
        ERR_PERIODIC = 2'd1,
        ERR_BURST    = 2'd2,
        ERR_RANDOM   = 2'd3
    } err_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/viterbi_chan_err_inj_if.sv
// Stream and status bundle of the channel error injector.
//   master : the encoder-side driver (drives word, mode, mask, clear;
//            receives the corrupted word and statistics)
//   slave  : the injector itself
interface viterbi_chan_err_inj_if
    import viterbi_chan_pkg::*;
#(
    parameter int SYM_W     = 2,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
);
    localparam int BL_W = $clog2(BURST_MAX + 1);

    logic             valid_i;
    logic [SYM_W-1:0] sym_i;
    err_mode_e        mode_i;
    logic [SYM_W-1:0] mask_i;
    logic [BL_W-1:0]  burst_len_i;
    logic             clr_i;

    logic             valid_o;
    logic [SYM_W-1:0] sym_o;
    logic             err_o;
    logic [CNT_W-1:0] word_ct_o;
    logic [CNT_W-1:0] inj_word_ct_o;
    logic [CNT_W-1:0] inj_bit_ct_o;
    logic             done_o;
    logic [CNT_W-1:0] mism_ct_o;

    modport master (
        output valid_i, sym_i, mode_i, mask_i, burst_len_i, clr_i,
        input  valid_o, sym_o, err_o, word_ct_o, inj_word_ct_o,
               inj_bit_ct_o, done_o, mism_ct_o
    );

    modport slave (
        input  valid_i, sym_i, mode_i, mask_i, burst_len_i, clr_i,
        output valid_o, sym_o, err_o, word_ct_o, inj_word_ct_o,
               inj_bit_ct_o, done_o, mism_ct_o
    );

endinterface

// File: rtl/viterbi_chan_err_inj_lfsr.sv
// chan_lfsr: 16-bit Galois LFSR used for pseudo-random word selection.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset, loads LFSR_SEED
//   adv    : advance one step
//   reseed : reload LFSR_SEED (wins over adv)
//   state  : current register contents
module chan_lfsr
    import viterbi_chan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        reseed,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LFSR_SEED;
        end else if (reseed) begin
            state <= LFSR_SEED;
        end else if (adv) begin
            // Right-shifting Galois form: the bit shifted out feeds the taps.
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/viterbi_chan_err_inj.sv
// viterbi_chan_err_inj: channel model between convolutional encoder and
// Viterbi decoder. Registers each encoded word and XORs mask_i onto words
// picked by a periodic, burst or pseudo-random policy inside an injection
// window counted from reset/clear, while keeping saturating statistics.
//   clk, rst : rising-edge clock, asynchronous active-low reset
//   bus      : viterbi_chan_err_inj_if.slave (word in, corrupted word out,
//              mode/mask/burst controls, clear, statistics, done)
// Optional build macro VITERBI_CHAN_CHECK_EN adds a checker comparing
// sym_o with a clean delayed copy and counting differing bits in
// mism_ct_o; without it mism_ct_o is tied to 0.
module viterbi_chan_err_inj
    import viterbi_chan_pkg::*;
#(
    parameter int SYM_W       = 2,
    parameter int PERIOD_LOG2 = 5,
    parameter int WINDOW      = 256,
    parameter int BURST_MAX   = 4,
    parameter int CNT_W       = 16
)(
    input logic                   clk,
    input logic                   rst,
    viterbi_chan_err_inj_if.slave bus
);

    localparam int          PERIOD   = 1 << PERIOD_LOG2;
    localparam logic [15:0] RND_MASK = 16'(PERIOD - 1);

    logic             vld_p1;
    logic [SYM_W-1:0] sym_p1;
    logic             err_p1;
    logic [CNT_W-1:0] word_ct;
    logic [CNT_W-1:0] inj_word_ct;
    logic [CNT_W-1:0] inj_bit_ct;
    logic [15:0]      lfsr;

    logic             accept;
    logic             in_window;
    logic             hit;
    logic             inject;
    logic             flip;
    logic [CNT_W-1:0] mask_bits;
    int               burst_l;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Clear takes priority: the word in a clear cycle is neither counted
    // nor eligible for injection.
    assign accept    = bus.valid_i && !bus.clr_i;
    assign in_window = 32'(word_ct) < 32'(WINDOW);
    assign mask_bits = CNT_W'(popcount(64'(bus.mask_i)));

    chan_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .adv    (accept),
        .reseed (bus.clr_i),
        .state  (lfsr)
    );

    always_comb begin
        burst_l = int'(bus.burst_len_i);
        if (burst_l > BURST_MAX) burst_l = BURST_MAX;
        if (burst_l > PERIOD)    burst_l = PERIOD;
        hit = 1'b0;
        unique case (bus.mode_i)
            ERR_OFF:      hit = 1'b0;
            // Last two words of every period.
            ERR_PERIODIC: hit = &word_ct[PERIOD_LOG2-1:1];
            ERR_BURST:    hit = int'(word_ct[PERIOD_LOG2-1:0]) < burst_l;
            ERR_RANDOM:   hit = (lfsr & RND_MASK) == 16'h0000;
            default:      hit = 1'b0;
        endcase
    end

    assign inject = accept && in_window && hit;
    assign flip   = inject && (bus.mask_i != '0);

    // ---- stage p1: registered word, flag and statistics ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            sym_p1      <= '0;
            err_p1      <= 1'b0;
            word_ct     <= '0;
            inj_word_ct <= '0;
            inj_bit_ct  <= '0;
        end else begin
            vld_p1 <= bus.valid_i;
            err_p1 <= flip;
            if (bus.valid_i) begin
                sym_p1 <= inject ? (bus.sym_i ^ bus.mask_i) : bus.sym_i;
            end
            if (bus.clr_i) begin
                word_ct     <= '0;
                inj_word_ct <= '0;
                inj_bit_ct  <= '0;
            end else if (bus.valid_i) begin
                word_ct <= sat_add(word_ct, CNT_W'(1));
                if (flip) begin
                    inj_word_ct <= sat_add(inj_word_ct, CNT_W'(1));
                    inj_bit_ct  <= sat_add(inj_bit_ct, mask_bits);
                end
            end
        end
    end

    assign bus.valid_o       = vld_p1;
    assign bus.sym_o         = sym_p1;
    assign bus.err_o         = err_p1;
    assign bus.word_ct_o     = word_ct;
    assign bus.inj_word_ct_o = inj_word_ct;
    assign bus.inj_bit_ct_o  = inj_bit_ct;
    assign bus.done_o        = 32'(word_ct) >= 32'(WINDOW);

`ifdef VITERBI_CHAN_CHECK_EN
    logic [SYM_W-1:0] clean_p1;
    logic [CNT_W-1:0] exp_bits_p1;
    logic [CNT_W-1:0] mism_ct;
    logic [CNT_W-1:0] mism_now;

    assign mism_now = CNT_W'(popcount(64'(sym_p1 ^ clean_p1)));

    // ---- stage p1: clean reference copy; p2: mismatch accumulation ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clean_p1    <= '0;
            exp_bits_p1 <= '0;
            mism_ct     <= '0;
        end else begin
            if (bus.valid_i) begin
                clean_p1    <= bus.sym_i;
                exp_bits_p1 <= flip ? mask_bits : '0;
            end
            if (bus.clr_i) begin
                mism_ct <= '0;
            end else if (vld_p1) begin
                mism_ct <= sat_add(mism_ct, mism_now);
            end
        end
    end

    always_comb begin
        if (rst && vld_p1) begin
            assert (mism_now == exp_bits_p1);
        end
    end

    assign bus.mism_ct_o = mism_ct;
`else
    assign bus.mism_ct_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_chan_err_inj.sv
// Self-checking bench for viterbi_chan_err_inj (default build). Random
// encoder words are driven through directed phases; a word-level reference
// model predicts every registered output and statistic.
module tb_viterbi_chan_err_inj;
    import viterbi_chan_pkg::*;

    localparam int SYM_W = 2, PERIOD_LOG2 = 5, WINDOW = 256, BURST_MAX = 4, CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_chan_err_inj_if #(.SYM_W(SYM_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) bus ();

    viterbi_chan_err_inj #(
        .SYM_W(SYM_W), .PERIOD_LOG2(PERIOD_LOG2), .WINDOW(WINDOW),
        .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int          m_wc, m_iw, m_ib;
    logic [15:0] m_lfsr;
    logic [1:0]  m_sym;
    logic        e_valid, e_err;
    logic        last_err;
    logic        seq1 [100];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        // multiply by x modulo x^16+x^14+x^13+x^11 in reflected Galois form
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int popc(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        m_wc = 0; m_iw = 0; m_ib = 0; m_lfsr = 16'hACE1; m_sym = 2'b00;
    endtask

    task automatic model_word(input logic v, input logic [1:0] s, input logic c);
        int  mode, L;
        bit  inj;
        e_valid = v;
        e_err   = 1'b0;
        mode    = int'(bus.mode_i);
        if (c) begin
            if (v) m_sym = s;
            m_wc = 0; m_iw = 0; m_ib = 0; m_lfsr = 16'hACE1;
        end else if (v) begin
            inj = 0;
            if (m_wc < WINDOW) begin
                case (mode)
                    1: inj = (m_wc % 32) >= 30;
                    2: begin
                        L = int'(bus.burst_len_i);
                        if (L > 4) L = 4;
                        inj = (m_wc % 32) < L;
                    end
                    3: inj = (m_lfsr % 32) == 0;
                    default: inj = 0;
                endcase
            end
            m_sym = inj ? (s ^ bus.mask_i) : s;
            if (inj && bus.mask_i != 2'b00) begin
                e_err = 1'b1;
                m_iw  = m_iw + 1;
                m_ib  = m_ib + popc(bus.mask_i);
            end
            if (m_wc < 65535) m_wc = m_wc + 1;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".valid_o"}, 32'(bus.valid_o), 32'(e_valid));
        check({ph, ".sym_o"}, 32'(bus.sym_o), 32'(m_sym));
        check({ph, ".err_o"}, 32'(bus.err_o), 32'(e_err));
        check({ph, ".word_ct"}, 32'(bus.word_ct_o), 32'(m_wc));
        check({ph, ".inj_word_ct"}, 32'(bus.inj_word_ct_o), 32'(m_iw));
        check({ph, ".inj_bit_ct"}, 32'(bus.inj_bit_ct_o), 32'(m_ib));
        check({ph, ".done_o"}, 32'(bus.done_o), 32'(m_wc >= WINDOW));
`ifndef VITERBI_CHAN_CHECK_EN
        check({ph, ".mism_ct"}, 32'(bus.mism_ct_o), 32'd0);
`endif
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at +1.
    task automatic step(input string ph, input logic v, input logic [1:0] s, input logic c);
        bus.valid_i = v; bus.sym_i = s; bus.clr_i = c;
        model_word(v, s, c);
        @(posedge clk); #1;
        check_all(ph);
        last_err = bus.err_o;
        @(negedge clk);
    endtask

    task automatic do_clear(input string ph);
        step(ph, 1'b0, 2'(($urandom)), 1'b1);
    endtask

    initial begin
        logic [1:0] s;
        int         ninj;
        bus.valid_i = 0; bus.sym_i = 0; bus.mode_i = ERR_OFF;
        bus.mask_i = 0; bus.burst_len_i = 0; bus.clr_i = 0;
        model_reset();
        e_valid = 0; e_err = 0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        @(negedge clk);

        // 1: periodic, full mask, 300 words
        bus.mode_i = ERR_PERIODIC; bus.mask_i = 2'b11;
        for (int i = 0; i < 300; i++) begin
            step("periodic", 1'b1, 2'($urandom), 1'b0);
            if (i == 30 || i == 255) check("periodic.err_at_w", 32'(last_err), 32'd1);
            if (i == 29 || i == 256) check("periodic.clean_at_w", 32'(last_err), 32'd0);
        end
        check("periodic.word_ct_final", 32'(bus.word_ct_o), 32'd300);
        check("periodic.inj_word_final", 32'(bus.inj_word_ct_o), 32'd16);
        check("periodic.inj_bit_final", 32'(bus.inj_bit_ct_o), 32'd32);

        // 2: burst of 3, low-bit mask
        do_clear("clr2");
        bus.mode_i = ERR_BURST; bus.burst_len_i = 3; bus.mask_i = 2'b01;
        for (int i = 0; i < 256; i++) begin
            s = 2'($urandom);
            step("burst3", 1'b1, s, 1'b0);
            check("burst3.sym_o_bit1", 32'(bus.sym_o[1]), 32'(s[1]));
        end
        check("burst3.inj_word_final", 32'(bus.inj_word_ct_o), 32'd24);
        check("burst3.inj_bit_final", 32'(bus.inj_bit_ct_o), 32'd24);

        // 3: burst length clamped to BURST_MAX, then zero length
        do_clear("clr3");
        bus.burst_len_i = 7; bus.mask_i = 2'b11;
        for (int i = 0; i < 256; i++) step("burst7", 1'b1, 2'($urandom), 1'b0);
        check("burst7.inj_word_final", 32'(bus.inj_word_ct_o), 32'd32);
        check("burst7.inj_bit_final", 32'(bus.inj_bit_ct_o), 32'd64);
        do_clear("clr3b");
        bus.burst_len_i = 0;
        for (int i = 0; i < 256; i++) step("burst0", 1'b1, 2'($urandom), 1'b0);
        check("burst0.inj_word_final", 32'(bus.inj_word_ct_o), 32'd0);

        // 4: random mode reproducible across a clear
        do_clear("clr4");
        bus.mode_i = ERR_RANDOM; bus.mask_i = 2'b10;
        for (int i = 0; i < 100; i++) begin
            step("random1", 1'b1, 2'($urandom), 1'b0);
            seq1[i] = last_err;
        end
        ninj = int'(bus.inj_word_ct_o);
        step("random_clr", 1'b1, 2'b01, 1'b1);
        check("random_clr.sym_clean", 32'(bus.sym_o), 32'h1);
        check("random_clr.err_low", 32'(bus.err_o), 32'd0);
        check("random_clr.word_ct_zero", 32'(bus.word_ct_o), 32'd0);
        for (int i = 0; i < 100; i++) begin
            step("random2", 1'b1, 2'($urandom), 1'b0);
            check("random2.err_repeat", 32'(last_err), 32'(seq1[i]));
        end
        check("random2.inj_word_repeat", 32'(bus.inj_word_ct_o), 32'(ninj));

        // 5: valid toggling, periodic switched off at w=31
        do_clear("clr5");
        bus.mode_i = ERR_PERIODIC; bus.mask_i = 2'b11;
        for (int w = 0; w < 32; w++) begin
            if (w == 31) bus.mode_i = ERR_OFF;
            step("toggle", 1'b1, 2'($urandom), 1'b0);
            if (w == 30) check("toggle.err_w30", 32'(last_err), 32'd1);
            if (w == 31) check("toggle.err_w31", 32'(last_err), 32'd0);
            step("toggle_idle", 1'b0, 2'($urandom), 1'b0);
            check("toggle_idle.word_ct", 32'(bus.word_ct_o), 32'(w + 1));
        end

        // 6: asynchronous reset in the middle of a burst run
        do_clear("clr6");
        bus.mode_i = ERR_BURST; bus.burst_len_i = 2; bus.mask_i = 2'b01;
        for (int i = 0; i < 100; i++) step("burst_pre_rst", 1'b1, 2'($urandom), 1'b0);
        bus.valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        e_valid = 0; e_err = 0;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        bus.mode_i = ERR_RANDOM; bus.mask_i = 2'b11;
        for (int i = 0; i < 64; i++) begin
            step("post_rst", 1'b1, 2'($urandom), 1'b0);
            if (i == 0) check("post_rst.first_word", 32'(bus.word_ct_o), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/viterbi_chan_err_inj.md
Name: viterbi_chan_err_inj

Overview:
Parametrised channel model placed between the convolutional encoder output and the Viterbi decoder input.
- Passes encoded symbols through a one-word register.
- XORs a programmable error mask onto selected words. Selection is periodic, burst or pseudo-random.
- Keeps word, injected-word and injected-bit statistics over a bounded injection window.
- Generalises the fixed 2-bit periodic injector used in the tx/rx loop to any symbol width, run-time mode, burst length and counter width.

Parameters:
- SYM_W, 2, symbol width in bits (code rate 1/SYM_W).
- PERIOD_LOG2, 5, log2 of injection period in words.
- WINDOW, 256, number of words from clear/reset during which injection is allowed.
- BURST_MAX, 4, maximum burst length in words.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  sym_i carries an encoded word this cycle.
- sym_i  in  SYM_W  encoder output word.
- mode_i  in  2  0=OFF, 1=PERIODIC, 2=BURST, 3=RANDOM; sampled per accepted word.
- mask_i  in  SYM_W  bits to flip on an injected word.
- burst_len_i  in  $clog2(BURST_MAX+1)  burst length in words, BURST mode only.
- clr_i  in  1  synchronous clear of counters and LFSR.
- valid_o  out  1  registered valid_i.
- sym_o  out  SYM_W  registered, possibly corrupted word.
- err_o  out  1  high with valid_o when sym_o was corrupted.
- word_ct_o  out  CNT_W  accepted words since reset/clear, saturating.
- inj_word_ct_o  out  CNT_W  injected words, saturating.
- inj_bit_ct_o  out  CNT_W  injected bits, saturating.
- done_o  out  1  high once word_ct_o >= WINDOW.
- mism_ct_o  out  CNT_W  checker mismatch count; see Optional Feature.

Behaviour:
Reset and latency:
- Reset: all outputs and internal state are 0; LFSR loads SEED.
- Latency is exactly 1 cycle: valid_o, sym_o and err_o follow valid_i and sym_i by one cycle.
- When valid_i=0: valid_o=0, err_o=0, sym_o holds its last value, and no counter or LFSR changes.

Word index and window:
- Word index w = word_ct value before increment, so the first word is w=0.
- Injection is allowed only while w < WINDOW. Beyond that, words pass through clean; word_ct keeps counting.

Injection condition per accepted word:
- OFF: never inject.
- PERIODIC: inject when w[PERIOD_LOG2-1:1] is all ones, i.e. 2 words per period.
- BURST: inject when w[PERIOD_LOG2-1:0] < L, where L = min(burst_len_i, BURST_MAX, 2^PERIOD_LOG2). L=0 means no injection.
- RANDOM: inject when LFSR[PERIOD_LOG2-1:0] == 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances on every accepted word in all modes, so sequences are reproducible per word index.

Effect of an injection:
- sym_o = sym_i ^ mask_i.
- err_o = (mask_i != 0).
- inj_word_ct increments only if mask_i != 0.
- inj_bit_ct adds popcount(mask_i).

Counter and control rules:
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_i has priority over valid_i. The word in a clr_i cycle passes through unmodified with err_o=0. That word is not counted, and the LFSR is reseeded rather than advanced.
- mode_i or mask_i changing mid-run takes effect on the next accepted word; no partial burst state is retained.
- Reset asserted mid-operation clears everything immediately; no word is in flight after release.

Optional Feature:
Macro: VITERBI_CHAN_CHECK_EN.
- Defined: a checker compares sym_o against a registered clean copy of sym_i on each valid_o cycle. Mismatching bits accumulate into mism_ct_o (saturating, cleared by clr_i). An immediate assertion fires if the mismatch count for a word differs from popcount of the applied mask.
- Undefined: mism_ct_o is tied to 0 and the checker logic is absent.

Decomposition:
Package viterbi_chan_pkg:
- typedef enum logic[1:0] err_mode_e {ERR_OFF, ERR_PERIODIC, ERR_BURST, ERR_RANDOM}.
- LFSR_SEED = 16'hACE1.
- LFSR_TAPS = 16'hB400.
- popcount function.

Sub-module: chan_lfsr, a 16-bit Galois LFSR with ports clk, rst, adv, reseed, state.

Test Plan:
1. PERIODIC, mask=2'b11, 300 consecutive valid words -> err_o on w=30,31,62,63,…,254,255; inj_word_ct=16, inj_bit_ct=32, word_ct=300, done_o high from the cycle after word 255 registers.
2. BURST, burst_len=3, mask=2'b01 -> injection on w=0,1,2,32,33,34,…; after 256 words inj_word_ct=24, inj_bit_ct=24, sym_o[1] always equals the delayed sym_i[1].
3. BURST, burst_len=7 with BURST_MAX=4 -> clamped to 4 per period, giving inj_word_ct=32 after 256 words; burst_len=0 gives inj_word_ct=0.
4. RANDOM, mask=2'b10, two runs separated by clr_i -> identical err_o sequences word-for-word; clr_i cycle word passes clean and word_ct=0 afterwards.
5. valid_i toggling 1/0 and mode_i switched PERIODIC->OFF at w=31 -> w=30 injected, w=31 clean, no counter change on idle cycles, 1-cycle latency preserved.
6. rst pulsed low at w=100 during BURST -> all outputs 0 asynchronously; after release first word is w=0 and the LFSR restarts from 16'hACE1.
